// File: rtl/mux_pkg.sv
// Shared definitions for the mux_rr_sel slice: mode constants, channel-id
// width helper and the beat record held in the output register.
// Optional feature macro used by the slice: MUX_PKT_LOCK_EN (packet lock).
package mux_pkg;

  localparam int unsigned MODE_SEL = 0;  // external select via sel
  localparam int unsigned MODE_RR  = 1;  // round-robin arbitration

  // Widest data/channel-id fields a beat can carry (DW <= 64, N_CH <= 16).
  localparam int unsigned BEAT_DW_MAX = 64;
  localparam int unsigned BEAT_CH_MAX = 4;

  // Channel-id width for n_ch channels; never below one bit.
  function automatic int unsigned ch_w(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : unsigned'($clog2(n_ch));
  endfunction

  // One captured beat: payload, source channel and end-of-packet flag.
  typedef struct packed {
    logic [BEAT_DW_MAX-1:0] data;
    logic [BEAT_CH_MAX-1:0] ch;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/mux_rr_sel_if.sv
// Handshake bundle between N_CH producers, the mux and one consumer.
//   master : producer/consumer side (drives sel, in_valid, in_data, out_ready)
//   slave  : mux side (drives in_ready, out_valid, out_data, out_ch)
// With MUX_PKT_LOCK_EN defined, in_last (master) and out_last (slave) are added.
interface mux_rr_sel_if
  import mux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8
);

  localparam int unsigned SW = ch_w(N_CH);

  logic [SW-1:0]      sel;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_ready;
  logic [SW-1:0]      out_ch;
`ifdef MUX_PKT_LOCK_EN
  logic [N_CH-1:0]    in_last;
  logic               out_last;

  modport master (
    output sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );
  modport slave (
    input  sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );
`else
  modport master (
    output sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input  sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted req at or above ptr,
// wrapping modulo N_CH.
//   req   : per-channel request
//   ptr   : highest-priority channel this cycle
//   grant : chosen channel (0 when nothing requested)
//   found : any request present
module rr_pick
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned SW   = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [SW-1:0]   grant,
  output logic            found
);

  // Walk offsets 0..N_CH-1 from ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(ptr) + k) % N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_rr_sel.sv
// N_CH x DW valid/ready multiplexer with a single registered output stage.
// Channel chosen by sel (MODE_SEL) or round-robin (MODE_RR).
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus.slave  : sel, in_valid, in_data, in_ready, out_valid, out_data,
//                out_ready, out_ch (+ in_last/out_last with MUX_PKT_LOCK_EN)
// MUX_PKT_LOCK_EN: a beat with last=0 locks the grant to its channel until a
// beat with last=1 from that channel is taken. Limits: DW <= 64, N_CH 2..16.
module mux_rr_sel
  import mux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned MODE = MODE_SEL
) (
  input  logic         clk,
  input  logic         rst,
  mux_rr_sel_if.slave  bus
);

  localparam int unsigned SW = ch_w(N_CH);
  localparam int unsigned NP = 1 << SW;

  logic            load_en;
  logic            found;
  logic            xfer;
  logic [SW-1:0]   grant;
  logic [SW-1:0]   mode_grant;
  logic            mode_found;
  logic [NP-1:0]   valid_pad;
  logic [N_CH-1:0] ready;
  logic [DW-1:0]   pick_data;
  logic            pick_last;
  beat_t           beat_q;
  beat_t           beat_d;
  logic            valid_q;
  logic            valid_d;
  logic            unused_beat;

  // Padding to a power of two makes an out-of-range sel read as not valid.
  assign valid_pad = NP'(bus.in_valid);
  assign load_en   = !valid_q || bus.out_ready;

  // Mode-specific channel choice.
  if (MODE == MODE_RR) begin : g_rr
    logic [SW-1:0] ptr_q;

    rr_pick #(.N_CH(N_CH)) u_pick (
      .req   (bus.in_valid),
      .ptr   (ptr_q),
      .grant (mode_grant),
      .found (mode_found)
    );

    // Priority moves just past the channel that was served.
    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_q <= '0;
      end else if (xfer) begin
        ptr_q <= (grant == SW'(N_CH - 1)) ? '0 : grant + SW'(1);
      end
    end
  end else begin : g_sel
    assign mode_grant = bus.sel;
    assign mode_found = valid_pad[bus.sel];
  end

`ifdef MUX_PKT_LOCK_EN
  logic          lock_q;
  logic          lock_d;
  logic [SW-1:0] lock_ch_q;
  logic [SW-1:0] lock_ch_d;

  // A held packet overrides the mode's choice.
  always_comb begin
    grant = mode_grant;
    found = mode_found;
    if (lock_q) begin
      grant = lock_ch_q;
      found = valid_pad[lock_ch_q];
    end
  end

  // Lock opens on a non-last beat and releases on the last beat.
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = !pick_last;
      lock_ch_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  assign grant = mode_grant;
  assign found = mode_found;
`endif

  // One-hot accept toward the granted producer; silent during reset.
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ready[i] = !rst && load_en && found && (grant == SW'(i));
    end
  end

  assign xfer = |(ready & bus.in_valid);

  // Steer the granted channel's payload.
  always_comb begin
    pick_data = '0;
    pick_last = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ready[i]) begin
        pick_data = bus.in_data[i*DW +: DW];
`ifdef MUX_PKT_LOCK_EN
        pick_last = bus.in_last[i];
`endif
      end
    end
  end

  // Output register next state: load replaces, drain clears valid only.
  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    if (xfer) begin
      beat_d.data = BEAT_DW_MAX'(pick_data);
      beat_d.ch   = BEAT_CH_MAX'(grant);
      beat_d.last = pick_last;
      valid_d     = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = beat_q.data[DW-1:0];
  assign bus.out_ch    = beat_q.ch[SW-1:0];
`ifdef MUX_PKT_LOCK_EN
  assign bus.out_last  = beat_q.last;
`endif

  // Beat fields wider than this instance needs are never read out.
  assign unused_beat = ^beat_q;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Bench for mux_rr_sel: a select-mode and a round-robin instance (4 x 8 bit)
// share stimulus and are checked every cycle against a behavioural model;
// a 3-channel select instance covers the out-of-range sel case.
module tb_mux_rr_sel;
  import mux_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    st_valid = '0;
  logic [N*DW-1:0] st_data  = '0;
  logic [1:0]      st_sel   = '0;
  logic            st_ordy  = 1'b0;
  logic [N-1:0]    st_last  = '0;

  mux_rr_sel_if #(.N_CH(N), .DW(DW)) bus_s ();
  mux_rr_sel_if #(.N_CH(N), .DW(DW)) bus_r ();
  mux_rr_sel_if #(.N_CH(3), .DW(DW)) bus_3 ();

  mux_rr_sel #(.N_CH(N), .DW(DW), .MODE(MODE_SEL)) u_sel (.clk(clk), .rst(rst), .bus(bus_s));
  mux_rr_sel #(.N_CH(N), .DW(DW), .MODE(MODE_RR))  u_rr  (.clk(clk), .rst(rst), .bus(bus_r));
  mux_rr_sel #(.N_CH(3), .DW(DW), .MODE(MODE_SEL)) u_s3  (.clk(clk), .rst(rst), .bus(bus_3));

  // Model state per instance (0 = select, 1 = round-robin) and its next value.
  logic        m_valid [2];
  logic [7:0]  m_data  [2];
  int unsigned m_ch    [2];
  logic        m_last  [2];
  int unsigned m_ptr   [2];
  logic        m_lock  [2];
  int unsigned m_lck_ch[2];
  logic        n_valid [2];
  logic [7:0]  n_data  [2];
  int unsigned n_ch    [2];
  logic        n_last  [2];
  int unsigned n_ptr   [2];
  logic        n_lock  [2];
  int unsigned n_lck_ch[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus_s.sel = st_sel; bus_s.in_valid = st_valid; bus_s.in_data = st_data; bus_s.out_ready = st_ordy;
    bus_r.sel = st_sel; bus_r.in_valid = st_valid; bus_r.in_data = st_data; bus_r.out_ready = st_ordy;
    bus_3.sel = st_sel; bus_3.in_valid = st_valid[2:0]; bus_3.in_data = st_data[23:0];
    bus_3.out_ready = st_ordy;
`ifdef MUX_PKT_LOCK_EN
    bus_s.in_last = st_last; bus_r.in_last = st_last; bus_3.in_last = st_last[2:0];
`endif
  endtask

  // Which channel the rules offer this cycle, if any.
  function automatic void choose(input int d, output logic fnd, output int unsigned g);
    fnd = 1'b0;
    g   = 0;
    if (m_lock[d]) begin
      g   = m_lck_ch[d];
      fnd = st_valid[g];
    end else if (d == 0) begin
      g   = st_sel;
      fnd = st_valid[g];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (st_valid[(m_ptr[d] + k) % N]) begin
          fnd = 1'b1;
          g   = (m_ptr[d] + k) % N;
        end
      end
    end
  endfunction

  // One clock: check in_ready vs model, step model at the edge, check outputs.
  task automatic cycle();
    logic        fnd;
    logic        load;
    int unsigned g;
    logic [N-1:0] er;
    logic [N-1:0] act;
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      choose(d, fnd, g);
      load = !m_valid[d] || st_ordy;
      er = '0;
      if (!rst && load && fnd) er[g] = 1'b1;
      act = (d == 0) ? bus_s.in_ready : bus_r.in_ready;
      check(d == 0 ? "sel_in_ready" : "rr_in_ready", 32'(act), 32'(er));
      n_valid[d] = m_valid[d]; n_data[d] = m_data[d]; n_ch[d] = m_ch[d]; n_last[d] = m_last[d];
      n_ptr[d] = m_ptr[d]; n_lock[d] = m_lock[d]; n_lck_ch[d] = m_lck_ch[d];
      if (rst) begin
        n_valid[d] = 1'b0; n_data[d] = '0; n_ch[d] = 0; n_last[d] = 1'b0;
        n_ptr[d] = 0; n_lock[d] = 1'b0; n_lck_ch[d] = 0;
      end else if (load && fnd) begin
        n_valid[d] = 1'b1;
        n_data[d]  = st_data[g*DW +: DW];
        n_ch[d]    = g;
        n_last[d]  = st_last[g];
        n_ptr[d]   = (g + 1) % N;
`ifdef MUX_PKT_LOCK_EN
        n_lock[d]   = !st_last[g];
        n_lck_ch[d] = g;
`endif
      end else if (st_ordy) begin
        n_valid[d] = 1'b0;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = n_valid[d]; m_data[d] = n_data[d]; m_ch[d] = n_ch[d]; m_last[d] = n_last[d];
      m_ptr[d] = n_ptr[d]; m_lock[d] = n_lock[d]; m_lck_ch[d] = n_lck_ch[d];
    end
    @(negedge clk);
    check("sel_out_valid", 32'(bus_s.out_valid), 32'(m_valid[0]));
    check("sel_out_data",  32'(bus_s.out_data),  32'(m_data[0]));
    check("sel_out_ch",    32'(bus_s.out_ch),    m_ch[0]);
    check("rr_out_valid",  32'(bus_r.out_valid), 32'(m_valid[1]));
    check("rr_out_data",   32'(bus_r.out_data),  32'(m_data[1]));
    check("rr_out_ch",     32'(bus_r.out_ch),    m_ch[1]);
`ifdef MUX_PKT_LOCK_EN
    check("sel_out_last",  32'(bus_s.out_last),  32'(m_last[0]));
    check("rr_out_last",   32'(bus_r.out_last),  32'(m_last[1]));
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_data[d] = '0; m_ch[d] = 0; m_last[d] = 1'b0;
      m_ptr[d] = 0; m_lock[d] = 1'b0; m_lck_ch[d] = 0;
    end
    @(negedge clk);

    // Reset.
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_out_valid", 32'(bus_s.out_valid), 32'd0);
    check("rst_out_data",  32'(bus_r.out_data),  32'd0);

    // Select mode: sel=2 carries A5.
    rst = 1'b0; st_sel = 2'd2; st_valid = 4'b0100; st_data = 32'h00A5_0000; st_ordy = 1'b1;
    drive(); #1;
    check("t_sel_ready", 32'(bus_s.in_ready), 32'h4);
    cycle();
    check("t_sel_valid", 32'(bus_s.out_valid), 32'd1);
    check("t_sel_data",  32'(bus_s.out_data),  32'hA5);
    check("t_sel_ch",    32'(bus_s.out_ch),    32'd2);

    // Backpressure: three stalled cycles with fresh valid inputs.
    st_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st_data = {8'h00, 8'(8'h11 + k), 16'h0000};
      drive(); #1;
      check("bp_ready", 32'(bus_s.in_ready), 32'h0);
      cycle();
      check("bp_hold", 32'(bus_s.out_data), 32'hA5);
    end
    // Release: back-to-back beats.
    st_ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      st_data = {8'h00, 8'(8'h30 + k), 16'h0000};
      cycle();
      check("stream_data", 32'(bus_s.out_data), 32'(8'h30 + k));
    end

    // Reset while holding a beat.
    rst = 1'b1;
    drive(); #1;
    check("rst_ready", 32'(bus_s.in_ready), 32'h0);
    cycle();
    check("rst_mid_valid", 32'(bus_s.out_valid), 32'd0);
    check("rst_mid_data",  32'(bus_s.out_data),  32'd0);
    check("rst_mid_ch",    32'(bus_s.out_ch),    32'd0);

    // Round-robin with every channel valid: 0,1,2,3,0,1.
    rst = 1'b0; st_valid = 4'hF; st_ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      st_data = $urandom;
      cycle();
      check("rr_seq", 32'(bus_r.out_ch), 32'(k % 4));
    end

    // Round-robin skip from ptr=1 over 4'b1001.
    rst = 1'b1; cycle();
    rst = 1'b0; st_valid = 4'b0001; cycle();
    st_valid = 4'b1001;
    cycle();
    check("rr_skip_3", 32'(bus_r.out_ch), 32'd3);
    cycle();
    check("rr_skip_0", 32'(bus_r.out_ch), 32'd0);

    // Three-channel instance: sel=3 is out of range.
    rst = 1'b1; cycle();
    rst = 1'b0; st_sel = 2'd3; st_valid = 4'b0111; st_data = 32'h00C3_B2A1;
    drive(); #1;
    check("s3_oob_ready", 32'(bus_3.in_ready), 32'h0);
    cycle();
    check("s3_oob_valid", 32'(bus_3.out_valid), 32'd0);
    st_sel = 2'd2;
    drive(); #1;
    check("s3_ready", 32'(bus_3.in_ready), 32'h4);
    cycle();
    check("s3_ch",   32'(bus_3.out_ch),   32'd2);
    check("s3_data", 32'(bus_3.out_data), 32'hC3);

`ifdef MUX_PKT_LOCK_EN
    // Packet lock: ch1 sends three beats while ch0/ch2 wait.
    rst = 1'b1; cycle();
    rst = 1'b0; st_valid = 4'b0001; st_last = 4'b0001; cycle();
    st_valid = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      st_last = (k == 2) ? 4'b0010 : 4'b0000;
      st_data = $urandom;
      cycle();
      check("lock_ch",   32'(bus_r.out_ch),   (k < 3) ? 32'd1 : 32'd2);
      check("lock_last", 32'(bus_r.out_last), (k == 2) ? 32'd1 : 32'd0);
    end
`endif

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 39) == 0);
      st_valid = 4'($urandom);
      st_data  = $urandom;
      st_sel   = 2'($urandom);
      st_ordy  = ($urandom_range(0, 3) != 0);
      st_last  = 4'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
